// File: rtl/dcache_resp_if.sv
// rtl/dcache_resp_if.sv - main-memory request/ack port of the data cache
interface dcache_resp_if;
  logic        mm_req;
  logic        mm_we;
  logic [31:0] mm_addr;
  logic [31:0] mm_wdata;
  logic [31:0] mm_rdata;
  logic        mm_ack;

  modport master (output mm_req, mm_we, mm_addr, mm_wdata, input mm_rdata, mm_ack);
  modport slave  (input mm_req, mm_we, mm_addr, mm_wdata, output mm_rdata, mm_ack);
endinterface

// File: rtl/dcache_resp.sv
// rtl/dcache_resp.sv - direct-mapped write-through, no-write-allocate data cache
// Loads hit with zero wait; misses and all stores stall via data_hit until mm_ack.
module dcache_resp #(
  parameter int INDEX_BITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [31:0]        addr,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               data_hit,
  dcache_resp_if.master      mm
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t                 state_q, state_d;
  logic [LINES-1:0]       valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q  [LINES];
  logic [31:0]            data_q [LINES];
  logic                   line_we;
  logic [TAG_W-1:0]       line_tag_d;
  logic [31:0]            line_data_d;
  logic                   mm_req_q, mm_req_d;
  logic                   mm_we_q, mm_we_d;
  logic [31:0]            mm_addr_q, mm_addr_d;
  logic [31:0]            mm_wdata_q, mm_wdata_d;
  logic [31:0]            resp_q, resp_d;

  logic [INDEX_BITS-1:0]  idx;
  logic [TAG_W-1:0]       tag;
  logic                   hit;
  logic                   unused_addr_bits;

  assign idx = addr[INDEX_BITS+1:2];
  assign tag = addr[31:INDEX_BITS+2];
  assign hit = valid_q[idx] && (tag_q[idx] == tag);
  assign unused_addr_bits = ^addr[1:0];

  assign mm.mm_req   = mm_req_q;
  assign mm.mm_we    = mm_we_q;
  assign mm.mm_addr  = mm_addr_q;
  assign mm.mm_wdata = mm_wdata_q;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    line_we     = 1'b0;
    line_tag_d  = tag;
    line_data_d = write_data;
    mm_req_d    = mm_req_q;
    mm_we_d     = mm_we_q;
    mm_addr_d   = mm_addr_q;
    mm_wdata_d  = mm_wdata_q;
    resp_d      = resp_q;
    data_hit    = 1'b0;
    read_data   = '0;

    case (state_q)
      IDLE: begin
        data_hit = 1'b1;
        // A simultaneous read+write is handled as a store.
        if (mem_write) begin
          data_hit   = 1'b0;
          state_d    = WRITE;
          mm_req_d   = 1'b1;
          mm_we_d    = 1'b1;
          mm_addr_d  = {addr[31:2], 2'b00};
          mm_wdata_d = write_data;
        end else if (mem_read) begin
          if (hit) begin
            read_data = data_q[idx];
          end else begin
            data_hit  = 1'b0;
            state_d   = FILL;
            mm_req_d  = 1'b1;
            mm_we_d   = 1'b0;
            mm_addr_d = {addr[31:2], 2'b00};
          end
        end
      end
      FILL: begin
        if (mm.mm_ack) begin
          line_we      = 1'b1;
          line_data_d  = mm.mm_rdata;
          valid_d[idx] = 1'b1;
          resp_d       = mm.mm_rdata;
          mm_req_d     = 1'b0;
          state_d      = DONE;
        end
      end
      WRITE: begin
        if (mm.mm_ack) begin
          // Write-through updates a resident line only; misses do not allocate.
          line_we     = hit;
          line_data_d = write_data;
          resp_d      = '0;
          mm_req_d    = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        data_hit  = 1'b1;
        read_data = resp_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      mm_req_q   <= 1'b0;
      mm_we_q    <= 1'b0;
      mm_addr_q  <= '0;
      mm_wdata_q <= '0;
      resp_q     <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      mm_req_q   <= mm_req_d;
      mm_we_q    <= mm_we_d;
      mm_addr_q  <= mm_addr_d;
      mm_wdata_q <= mm_wdata_d;
      resp_q     <= resp_d;
    end
  end

  // Tag/data arrays need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[idx]  <= line_tag_d;
      data_q[idx] <= line_data_d;
    end
  end
endmodule

// File: doc/dcache_resp.md
# dcache_resp

Direct-mapped, write-through, no-write-allocate data cache that answers MEM-stage load/store requests and produces the `data_hit` stall signal and load data consumed by the MEM/WB pipeline register. It sits between the EX/MEM register outputs and the main-memory port. Misses and all stores go to main memory over a req/ack handshake. `data_hit` stays low until the access completes, which freezes the pipeline.

## Interface
- INDEX_BITS, 4, number of index bits; the cache has 2^INDEX_BITS one-word lines
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_read  in  1  load request from EX/MEM control; held stable while data_hit=0
- mem_write  in  1  store request; held stable while data_hit=0
- addr  in  32  byte address; bits [1:0] ignored
- write_data  in  32  store data
- read_data  out  32  load data to MEM/WB `Read_data_in`
- data_hit  out  1  1 = access complete or no access this cycle; 0 = stall
- mm_req  out  1  main-memory request, registered
- mm_we  out  1  1 = write, 0 = read; valid while mm_req=1
- mm_addr  out  32  word-aligned address (addr[1:0] forced to 0), registered
- mm_wdata  out  32  store data, registered
- mm_rdata  in  32  read data; valid in the cycle where mm_ack=1
- mm_ack  in  1  one-cycle completion pulse from main memory

## Operation
- Address fields:
  - index = addr[INDEX_BITS+1:2]
  - tag = addr[31:INDEX_BITS+2]
- Per-line storage: valid bit, tag, 32-bit data word.
- Hit = valid[index] && tag match.
- States: IDLE, FILL, WRITE, DONE.
- IDLE transitions:
  - no request: data_hit=1 and read_data=0.
  - mem_read and hit: data_hit=1 combinationally and read_data=line data. Stay in IDLE.
  - mem_read and miss: data_hit=0. Go to FILL. Register mm_addr and set mm_req=1, mm_we=0.
  - mem_write, hit or miss: data_hit=0. Go to WRITE. Set mm_req=1, mm_we=1, and register mm_addr/mm_wdata.
  - mem_read and mem_write together: treated as a write.
- FILL: mm_req held at 1. When mm_ack=1:
  - write mm_rdata into line[index], set its tag and valid bit
  - latch the word into a response register
  - drop mm_req and go to DONE.
- WRITE: mm_req held at 1. When mm_ack=1:
  - if the line hits, update its data with write_data (write-through)
  - on a miss, leave the cache unchanged (no allocate)
  - drop mm_req and go to DONE.
- DONE: data_hit=1 for exactly one cycle; the pipeline advances on this edge.
  - read_data = response register after a fill, 0 after a write.
  - Next state is always IDLE. The following request is evaluated in IDLE.
- mm_ack while in IDLE or DONE is ignored.
- Outputs and state on reset:
  - state=IDLE, all valid bits=0
  - mm_req=0, mm_we=0, mm_addr=0, mm_wdata=0, response register=0
  - data_hit follows the IDLE rule (1 while no request).
- Reset mid-FILL or mid-WRITE:
  - mm_req drops immediately and asynchronously
  - the fill is discarded and the line stays invalid
  - a pending ack arriving after reset is ignored.

## Timing
- Read hit: zero wait; data_hit and read_data are valid in the same cycle as the request.
- Read miss, with mm_ack arriving in the k-th cycle after mm_req rises (k≥1): data_hit=0 for k+1 cycles, then 1 in DONE.
  - Total request-to-complete = k+2 cycles.
- Store: same cycle count as a read miss, for both hit and miss.
- mm_req rises on the edge after the request is seen in IDLE. It falls on the edge where mm_ack is sampled.
- mm_addr, mm_we and mm_wdata are constant while mm_req=1.
- Back-to-back requests: a request presented in the cycle after DONE is evaluated in IDLE, so there is no extra bubble.

## Test plan
- Reset, then load addr=0x0000_0040 with mm_ack 3 cycles after req and mm_rdata=0xDEAD_BEEF:
  - data_hit low for 4 cycles, then DONE with read_data=0xDEAD_BEEF.
  - A repeat load hits in the same cycle with 0xDEAD_BEEF.
- Conflict miss: after the fill above, load 0x0000_0080 (same index, different tag) -> miss, mm_req with mm_addr=0x0000_0080. The line is replaced.
- Store hit, write_data=0x1234_5678 to 0x0000_0080:
  - mm_req=1, mm_we=1, mm_wdata=0x1234_5678.
  - After ack, a load of 0x0000_0080 hits and returns 0x1234_5678 with no mm_req.
- Store miss to 0x0000_0100 -> write goes to memory. A following load of 0x0000_0100 misses (no allocate).
- Assert rst_n=0 mid-FILL:
  - mm_req drops immediately and a late ack is ignored.
  - A reload of the same address misses again.
- Set mem_read=mem_write=1 on addr 0x0000_0004 -> write access (mm_we=1), and the cache is not filled.
